// File: rtl/mysqrtip_axil_slave.sv
// AXI4-Lite register front-end of the square-root IP with a bit-serial
// integer square-root engine that produces one root bit per clock.
module mysqrtip_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            done_irq
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [31:0] operand_q, operand_d;
  logic [31:0] x_q, x_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        irq_q, irq_d;
  logic        awready_q, awready_d;
  logic        bvalid_q, bvalid_d;
  logic        arready_q, arready_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        wr_en, rd_en, start;
  logic [1:0]  wr_sel, rd_sel;
  logic [31:0] rd_mux;
  logic [17:0] rem_sh, trial;
  logic        unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // A transfer happens on the edge where VALID and READY are both high. READY is
  // a registered one-cycle pulse, raised only when the response slot is free, so
  // AW and W are always taken together and never while a response is pending.
  assign wr_en  = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_en  = arready_q & S_AXI_ARVALID;
  assign wr_sel = S_AXI_AWADDR[3:2];
  assign rd_sel = S_AXI_ARADDR[3:2];
  assign start  = wr_en && (wr_sel == 2'd1) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];

  always_comb begin
    rd_mux = 32'h0;
    case (rd_sel)
      2'd0:    rd_mux = operand_q;
      2'd2:    rd_mux = {16'h0, result_q};
      2'd3:    rd_mux = {30'h0, done_q, state_q == ST_RUN};
      default: rd_mux = 32'h0;
    endcase
  end

  always_comb begin
    awready_d = !awready_q && S_AXI_AWVALID && S_AXI_WVALID && !bvalid_q;
    bvalid_d  = bvalid_q ? !S_AXI_BREADY : wr_en;
    arready_d = !arready_q && S_AXI_ARVALID && !rvalid_q;
    rvalid_d  = rvalid_q ? !S_AXI_RREADY : rd_en;
    rdata_d   = rd_en ? rd_mux : rdata_q;
    operand_d = operand_q;
    if (wr_en && (wr_sel == 2'd0)) begin
      for (int b = 0; b < 4; b++) begin
        if (S_AXI_WSTRB[b]) operand_d[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // Restoring square root: bring down two operand bits, try subtracting 4*root+1.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    rem_d    = rem_q;
    root_d   = root_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = done_q;
    irq_d    = 1'b0;
    rem_sh   = {rem_q[15:0], x_q[31:30]};
    trial    = {root_q, 2'b01};
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          x_d     = operand_q;
          rem_d   = 18'h0;
          root_d  = 16'h0;
          cnt_d   = 4'd15;
          done_d  = 1'b0;
        end
      end
      ST_RUN: begin
        x_d = {x_q[29:0], 2'b00};
        if (rem_sh >= trial) begin
          rem_d  = rem_sh - trial;
          root_d = {root_q[14:0], 1'b1};
        end else begin
          rem_d  = rem_sh;
          root_d = {root_q[14:0], 1'b0};
        end
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd0) begin
          state_d  = ST_IDLE;
          result_d = root_d;
          done_d   = 1'b1;
          irq_d    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q   <= ST_IDLE;
      operand_q <= 32'h0;
      x_q       <= 32'h0;
      rem_q     <= 18'h0;
      root_q    <= 16'h0;
      cnt_q     <= 4'd0;
      result_q  <= 16'h0;
      done_q    <= 1'b0;
      irq_q     <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= 32'h0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      x_q       <= x_d;
      rem_q     <= rem_d;
      root_q    <= root_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      done_q    <= done_d;
      irq_q     <= irq_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = awready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = 2'b00;
  assign done_irq      = irq_q;

endmodule

// File: tb/tb_mysqrtip_axil_slave.sv
// Directed bench for mysqrtip_axil_slave: register access, strobes, engine
// results and latency, back-pressure and asynchronous reset mid-computation.
module tb_mysqrtip_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid, done_irq;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mysqrtip_axil_slave dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .done_irq(done_irq)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic accept_aw_w();
    int n = 0;
    while (!(awready && wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("aw_w_accept", {30'h0, awready, wready}, 32'h3);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid  = 1'b0;
  endtask

  task automatic collect_b();
    int n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("bvalid", bvalid, 1);
    check_val("bresp", bresp, 0);
    @(negedge clk);
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    accept_aw_w();
    collect_b();
  endtask

  task automatic accept_ar();
    int n = 0;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("ar_accept", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
  endtask

  task automatic collect_r(output logic [31:0] d);
    int n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("rvalid", rvalid, 1);
    check_val("rresp", rresp, 0);
    d = rdata;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    accept_ar();
    collect_r(d);
  endtask

  task automatic wait_irq(output int k);
    k = 0;
    while (!done_irq && k < 60) begin
      @(negedge clk);
      k++;
    end
    check_val("irq_seen", done_irq, 1);
  endtask

  task automatic run_sqrt(input logic [31:0] op, input logic [31:0] exp);
    logic [31:0] d;
    int k;
    axi_write(4'h0, op, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    wait_irq(k);
    @(negedge clk);
    axi_read(4'h8, d);
    check_val($sformatf("root_of_%08h", op), d, exp);
  endtask

  function automatic logic [31:0] idle_outs();
    return {22'h0, awready, wready, bvalid, arready, rvalid, done_irq, bresp, rresp};
  endfunction

  initial begin
    logic [31:0] d;
    logic        bad;
    int          k;

    // power-on reset
    #2 rst_n = 1'b0;
    #1 check_val("reset_outs", idle_outs(), 0);
    check_val("reset_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    axi_read(4'h0, d); check_val("rst_operand", d, 0);
    axi_read(4'h8, d); check_val("rst_result", d, 0);
    axi_read(4'hC, d); check_val("rst_status", d, 0);

    // byte strobes and read-only / write-only registers
    axi_write(4'h0, 32'h1122_3344, 4'b0101);
    axi_read(4'h0, d); check_val("wstrb_0101", d, 32'h0022_0044);
    axi_write(4'h8, 32'hDEAD_BEEF, 4'hF);
    axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
    axi_read(4'h8, d); check_val("ro_result", d, 0);
    axi_read(4'hC, d); check_val("ro_status", d, 0);
    axi_read(4'h4, d); check_val("ctrl_reads_0", d, 0);

    // 81 -> 9 with exact completion timing
    axi_write(4'h0, 32'h51, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    wait_irq(k);
    check_val("irq_latency", k, 15);
    @(negedge clk);
    check_val("irq_one_cycle", done_irq, 0);
    axi_read(4'hC, d); check_val("status_done", d, 32'h2);
    axi_read(4'h8, d); check_val("result_81", d, 32'h9);

    // boundary and directed operands
    run_sqrt(32'h0000_0000, 32'h0000);
    run_sqrt(32'h0000_0001, 32'h0001);
    run_sqrt(32'hFFFF_FFFF, 32'hFFFF);
    run_sqrt(32'hFFFE_0001, 32'hFFFF);
    run_sqrt(32'hFFFE_0000, 32'hFFFE);
    run_sqrt(32'h000F_4240, 32'h03E8);
    run_sqrt(32'h0000_0063, 32'h0009);

    // START while busy is ignored; operand write during run does not disturb it
    axi_write(4'h0, 32'h90, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    axi_read(4'hC, d); check_val("status_busy", d, 32'h1);
    axi_write(4'h0, 32'h40, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    wait_irq(k);
    @(negedge clk);
    axi_read(4'h8, d); check_val("result_unaltered", d, 32'hC);
    axi_read(4'h0, d); check_val("operand_new", d, 32'h40);
    axi_read(4'hC, d); check_val("status_after", d, 32'h2);
    axi_write(4'h4, 32'h1, 4'hF);
    wait_irq(k);
    @(negedge clk);
    axi_read(4'h8, d); check_val("result_second", d, 32'h8);

    // write response back-pressure with a second write queued behind it
    bready = 1'b0;
    @(negedge clk);
    awaddr = 4'h0; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    accept_aw_w();
    awaddr = 4'h0; wdata = 32'h5A5A_5A5A; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!bvalid || bresp != 2'b00 || awready || wready) bad = 1'b1;
    end
    check_val("b_stall", bad, 0);
    bready = 1'b1;
    accept_aw_w();
    collect_b();
    axi_read(4'h0, d); check_val("queued_write", d, 32'h5A5A_5A5A);

    // read response back-pressure with a second read queued behind it
    rready = 1'b0;
    @(negedge clk);
    araddr = 4'h0; arvalid = 1'b1;
    accept_ar();
    araddr = 4'hC; arvalid = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!rvalid || rdata != 32'h5A5A_5A5A || arready) bad = 1'b1;
    end
    check_val("r_stall", bad, 0);
    rready = 1'b1;
    accept_ar();
    collect_r(d);
    check_val("queued_read", d, 32'h2);

    // asynchronous reset five iterations into a run, with a read response pending
    axi_write(4'h0, 32'hFFFF_FFFF, 4'hF);
    axi_write(4'h4, 32'h1, 4'hF);
    rready = 1'b0;
    @(negedge clk);
    araddr = 4'h0; arvalid = 1'b1;
    accept_ar();
    @(negedge clk);
    check_val("pre_rst_rdata", rdata, 32'hFFFF_FFFF);
    #2 rst_n = 1'b0;
    #1 check_val("midrun_rst_outs", idle_outs(), 0);
    check_val("midrun_rst_rdata", rdata, 0);
    @(negedge clk);
    rst_n  = 1'b1;
    rready = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done_irq) bad = 1'b1;
    end
    check_val("no_irq_after_rst", bad, 0);
    axi_read(4'hC, d); check_val("post_rst_status", d, 0);
    axi_read(4'h0, d); check_val("post_rst_operand", d, 0);
    axi_read(4'h8, d); check_val("post_rst_result", d, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
